// File: rtl/mkio_pkg.sv
// Shared types and command-word layout for the MKIO bus controller.
package mkio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_WAIT_STATUS,
    ST_RX_DATA,
    ST_FINISH
  } bc_state_e;

  typedef enum logic [1:0] {
    TXP_FETCH,
    TXP_LOAD,
    TXP_REQ,
    TXP_SENT
  } tx_phase_e;

  localparam int CW_ADDR_MSB = 15;
  localparam int CW_ADDR_LSB = 11;
  localparam int CW_TR_BIT   = 10;
  localparam int CW_SA_MSB   = 9;
  localparam int CW_SA_LSB   = 5;
  localparam int CW_WC_MSB   = 4;
  localparam int CW_WC_LSB   = 0;

  localparam logic [4:0] BCAST_ADDR = 5'd31;

  localparam int DEF_RESP_TIMEOUT = 448;
  localparam int TMR_W            = 9;

  function automatic logic [15:0] make_cw(input logic [4:0] addr, input logic tr,
                                          input logic [4:0] sa, input logic [4:0] wc);
    logic [15:0] cw;
    cw = '0;
    cw[CW_ADDR_MSB:CW_ADDR_LSB] = addr;
    cw[CW_TR_BIT]               = tr;
    cw[CW_SA_MSB:CW_SA_LSB]     = sa;
    cw[CW_WC_MSB:CW_WC_LSB]     = wc;
    return cw;
  endfunction

endpackage

// File: rtl/mkio_bc_buffer.sv
// 32x16 data buffer: host port and BC port, both synchronous, BC write wins on collision.
module mkio_bc_buffer (
  input  logic        clk32,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  input  logic        bc_we,
  input  logic [4:0]  bc_addr,
  input  logic [15:0] bc_wdata,
  output logic [15:0] bc_rdata
);

  logic [15:0] mem [32];

  // Later assignment wins, so the BC write overrides a same-address host write.
  always_ff @(posedge clk32) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (bc_we)   mem[bc_addr]   <= bc_wdata;
    host_rdata <= mem[host_addr];
    bc_rdata   <= mem[bc_addr];
  end

endmodule

// File: rtl/mkio_bc.sv
// MKIO bus-controller sequencer: command word, data transfer to/from the buffer,
// status check with response timeout.
//
// state          | meaning
// ST_IDLE        | waiting for start
// ST_TX_CMD      | sending the command word
// ST_TX_DATA     | sending buffer[0..n-1] as data words
// ST_WAIT_STATUS | waiting for the RT status word (timed)
// ST_RX_DATA     | receiving data words into buffer[0..n-1] (timed)
// ST_FINISH      | pulse done, drop busy
module mkio_bc
  import mkio_pkg::*;
#(
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic        tr,
  input  logic [4:0]  subaddr,
  input  logic [4:0]  word_count,
  input  logic        buf_we,
  input  logic [4:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  output logic [15:0] buf_rdata,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic        busy,
  output logic        done,
  output logic [15:0] status_word,
  output logic        err_timeout,
  output logic        err_parity,
  output logic        err_format
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  bc_state_e        state;
  tx_phase_e        tx_ph;
  logic [4:0]       rq_addr;
  logic             rq_tr;
  logic [4:0]       idx;
  logic [4:0]       last_idx;
  logic [TMR_W-1:0] tmr;
  logic             rx_done_q;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [15:0]      wr_data;
  logic [15:0]      bc_rdata;
  logic [4:0]       bc_addr;
  logic             rx_edge;
  logic             tmr_tc;
  logic             st_bad_fmt;

  assign rx_edge    = rx_done & ~rx_done_q;
  assign tmr_tc     = (tmr == '0);
  assign st_bad_fmt = !rx_cd || (rx_data[CW_ADDR_MSB:CW_ADDR_LSB] != rq_addr);
  assign bc_addr    = wr_en ? wr_addr : idx;

  mkio_bc_buffer u_buf (
    .clk32      (clk32),
    .host_we    (buf_we),
    .host_addr  (buf_addr),
    .host_wdata (buf_wdata),
    .host_rdata (buf_rdata),
    .bc_we      (wr_en),
    .bc_addr    (bc_addr),
    .bc_wdata   (wr_data),
    .bc_rdata   (bc_rdata)
  );

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx_ph       <= TXP_FETCH;
      rq_addr     <= '0;
      rq_tr       <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      tmr         <= '0;
      rx_done_q   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      tx_ready    <= 1'b0;
      tx_data     <= '0;
      tx_cd       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status_word <= '0;
      err_timeout <= 1'b0;
      err_parity  <= 1'b0;
      err_format  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rq_addr     <= rt_addr;
            rq_tr       <= tr;
            last_idx    <= word_count - 5'd1;   // wc=0 wraps to 31, i.e. 32 words
            idx         <= '0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_parity  <= 1'b0;
            err_format  <= 1'b0;
            if (tr && rt_addr == BCAST_ADDR) begin
              err_format <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              tx_data  <= make_cw(rt_addr, tr, subaddr, word_count);
              tx_cd    <= 1'b1;
              tx_ready <= 1'b1;
              tx_ph    <= TXP_REQ;
              state    <= ST_TX_CMD;
            end
          end
        end
        ST_TX_CMD, ST_TX_DATA: begin
          // FETCH gives the registered buffer read one cycle to follow idx.
          case (tx_ph)
            TXP_FETCH: tx_ph <= TXP_LOAD;
            TXP_LOAD: begin
              tx_data  <= bc_rdata;
              tx_cd    <= 1'b0;
              tx_ready <= 1'b1;
              tx_ph    <= TXP_REQ;
            end
            TXP_REQ: begin
              if (tx_busy) begin
                tx_ready <= 1'b0;
                tx_ph    <= TXP_SENT;
              end
            end
            TXP_SENT: begin
              if (!tx_busy) begin
                tmr   <= TMR_LOAD;
                tx_ph <= TXP_FETCH;
                if (state == ST_TX_CMD) begin
                  idx   <= '0;
                  state <= rq_tr ? ST_WAIT_STATUS : ST_TX_DATA;
                end else if (idx != last_idx) begin
                  idx <= idx + 5'd1;
                end else begin
                  state <= (rq_addr == BCAST_ADDR) ? ST_FINISH : ST_WAIT_STATUS;
                end
              end
            end
            default: tx_ph <= TXP_FETCH;
          endcase
        end
        ST_WAIT_STATUS: begin
          if (rx_edge) begin
            status_word <= rx_data;
            if (p_error)    err_parity <= 1'b1;
            if (st_bad_fmt) err_format <= 1'b1;
            if (p_error || st_bad_fmt || !rq_tr) begin
              state <= ST_FINISH;
            end else begin
              idx   <= '0;
              tmr   <= TMR_LOAD;
              state <= ST_RX_DATA;
            end
          end else if (tmr_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_FINISH;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end
        ST_RX_DATA: begin
          if (rx_edge) begin
            if (p_error) err_parity <= 1'b1;
            if (rx_cd)   err_format <= 1'b1;
            if (p_error || rx_cd) begin
              state <= ST_FINISH;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= idx;
              wr_data <= rx_data;
              tmr     <= TMR_LOAD;
              if (idx == last_idx) state <= ST_FINISH;
              else                 idx   <= idx + 5'd1;
            end
          end else if (tmr_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_FINISH;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end
        ST_FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b0;
          tmr      <= '0;
          idx      <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mkio_bc.sv
// Bench for mkio_bc: transmitter responder, RT responder driven from one directed
// sequence plus randomized transactions, checked against a transaction-level model.
module tb_mkio_bc;
  import mkio_pkg::*;

  localparam int RESP = DEF_RESP_TIMEOUT;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rt_addr = '0;
  logic        tr = 1'b0;
  logic [4:0]  subaddr = '0;
  logic [4:0]  word_count = '0;
  logic        buf_we = 1'b0;
  logic [4:0]  buf_addr = '0;
  logic [15:0] buf_wdata = '0;
  logic [15:0] buf_rdata;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_busy = 1'b0;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_cd = 1'b0;
  logic        p_error = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] status_word;
  logic        err_timeout;
  logic        err_parity;
  logic        err_format;

  mkio_bc dut (
    .clk32(clk32), .reset(reset), .start(start), .rt_addr(rt_addr), .tr(tr),
    .subaddr(subaddr), .word_count(word_count), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_cd(tx_cd), .tx_busy(tx_busy), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd),
    .p_error(p_error), .busy(busy), .done(done), .status_word(status_word),
    .err_timeout(err_timeout), .err_parity(err_parity), .err_format(err_format)
  );

  always #5 clk32 = ~clk32;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int last_det = 0;
  int tx_cnt = 0;
  logic [16:0] sent_q[$];
  logic [15:0] ref_buf[32];
  logic [15:0] exp_status = '0;

  always @(posedge clk32) cyc++;

  always @(negedge clk32) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Transmitter stand-in: accepts a word on tx_ready, stays busy a random time.
  always @(negedge clk32) begin
    if (reset) begin
      tx_busy = 1'b0;
      tx_cnt  = 0;
    end else if (tx_busy) begin
      if (tx_cnt == 0) begin
        tx_busy  = 1'b0;
        fall_cyc = cyc + 1;
      end else begin
        tx_cnt--;
      end
    end else if (tx_ready === 1'b1) begin
      sent_q.push_back({tx_cd, tx_data});
      tx_busy = 1'b1;
      tx_cnt  = int'($urandom_range(2, 8));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hw(input int ad, input logic [15:0] d);
    @(negedge clk32);
    buf_we = 1'b1; buf_addr = 5'(ad); buf_wdata = d;
    @(negedge clk32);
    buf_we = 1'b0;
    ref_buf[ad] = d;
  endtask

  task automatic check_buf();
    for (int i = 0; i < 32; i++) begin
      buf_addr = 5'(i);
      @(negedge clk32);
      chk("buf_rd", 32'(buf_rdata), 32'(ref_buf[i]));
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic cd, input logic pe);
    rx_data = d; rx_cd = cd; p_error = pe; rx_done = 1'b1;
    last_det = cyc + 1;
    @(negedge clk32);
    @(negedge clk32);
    rx_done = 1'b0; p_error = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_cd"}, 32'(tx_cd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_status"}, 32'(status_word), 32'd0);
    chk({tag, "_errs"}, 32'({err_timeout, err_parity, err_format}), 32'd0);
  endtask

  // dly: cycles from tx_busy fall to the status rx_done edge, <0 = no answer.
  // pe_at: index of the data word carrying a parity error, -1 = none.
  task automatic do_txn(input logic [4:0] a, input logic t, input logic [4:0] sa,
                        input logic [4:0] wc, input int dly, input logic [4:0] st_a,
                        input logic st_pe, input int pe_at, input bit rnd);
    int n, d0, budget, start_edge, exp_done;
    bit illegal, bcast, want_st;
    logic e_t, e_p, e_f;
    logic [16:0] exp_q[$];
    logic [15:0] st, w;
    n = (wc == 5'd0) ? 32 : int'(wc);
    illegal = t && (a == 5'd31);
    bcast   = !t && (a == 5'd31);
    want_st = !illegal && !bcast;
    e_t = 1'b0; e_p = 1'b0; e_f = illegal;
    if (!illegal) begin
      exp_q.push_back({1'b1, a, t, sa, wc});
      if (!t) for (int i = 0; i < n; i++) exp_q.push_back({1'b0, ref_buf[i]});
    end
    sent_q.delete();
    d0 = done_cnt;
    @(negedge clk32);
    rt_addr = a; tr = t; subaddr = sa; word_count = wc; start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk32);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("tx_ready_rise", 32'(tx_ready), 32'(!illegal));
    exp_done = start_edge + 1;

    budget = 0;
    while (!(sent_q.size() == exp_q.size() && !tx_busy && tx_ready !== 1'b1) && budget < 4000) begin
      @(negedge clk32);
      budget++;
    end
    if (bcast) exp_done = fall_cyc + 1;

    if (want_st) begin
      if (dly < 0) begin
        while (cyc < fall_cyc + RESP - 1) @(negedge clk32);
        chk("tmo_early", 32'(err_timeout), 32'd0);
        @(negedge clk32);
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        chk("tmo_done_lag", 32'(done), 32'd0);
        @(negedge clk32);
        chk("tmo_done", 32'(done), 32'd1);
        e_t = 1'b1;
        exp_done = fall_cyc + RESP + 1;
      end else begin
        while (cyc < fall_cyc + dly - 1) @(negedge clk32);
        st = rnd ? {st_a, 11'($urandom)} : {st_a, 11'h000};
        send_word(st, 1'b1, st_pe);
        exp_status = st;
        if (st_pe) e_p = 1'b1;
        if (st_a != a) e_f = 1'b1;
        if (t && !st_pe && st_a == a) begin
          for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk32);
            w = rnd ? 16'($urandom) : 16'(i);
            send_word(w, 1'b0, 1'(i == pe_at));
            if (i == pe_at) begin
              e_p = 1'b1;
              break;
            end
            ref_buf[i] = w;
          end
        end
        exp_done = last_det + 1;
      end
    end

    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(negedge clk32);
      budget++;
    end
    repeat (2) @(negedge clk32);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("done_time", 32'(done_cyc), 32'(exp_done));
    chk("busy_fall", 32'(busy), 32'd0);
    chk("err_timeout", 32'(err_timeout), 32'(e_t));
    chk("err_parity", 32'(err_parity), 32'(e_p));
    chk("err_format", 32'(err_format), 32'(e_f));
    chk("status_word", 32'(status_word), 32'(exp_status));
    chk("tx_count", 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk("tx_word", 32'(sent_q[i]), 32'(exp_q[i]));
    check_buf();
  endtask

  initial begin
    int d0, budget;
    logic [4:0] ra, rs, rw, sa_r;
    logic rt;
    int pe;

    repeat (3) @(negedge clk32);
    check_idle_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < 32; i++) hw(i, 16'($urandom));
    check_buf();

    hw(0, 16'h1234);
    hw(1, 16'hABCD);
    do_txn(5'd3, 1'b0, 5'd1, 5'd2, 20, 5'd3, 1'b0, -1, 1'b0);
    chk("cw_0x1822", 32'(sent_q.size() > 0 ? sent_q[0] : 17'h0), 32'h11822);

    do_txn(5'd5, 1'b1, 5'd0, 5'd0, 30, 5'd5, 1'b0, -1, 1'b0);
    chk("cw_0x2C00", 32'(sent_q.size() > 0 ? sent_q[0] : 17'h0), 32'h12C00);

    do_txn(5'd31, 1'b0, 5'd2, 5'd1, 0, 5'd0, 1'b0, -1, 1'b1);
    do_txn(5'd3, 1'b1, 5'd1, 5'd1, -1, 5'd3, 1'b0, -1, 1'b0);
    do_txn(5'd3, 1'b0, 5'd1, 5'd1, 447, 5'd3, 1'b0, -1, 1'b0);
    do_txn(5'd3, 1'b1, 5'd1, 5'd2, 448, 5'd3, 1'b0, -1, 1'b1);
    do_txn(5'd3, 1'b0, 5'd1, 5'd1, 10, 5'd4, 1'b0, -1, 1'b0);
    do_txn(5'd6, 1'b1, 5'd2, 5'd4, 10, 5'd6, 1'b0, 2, 1'b1);
    do_txn(5'd7, 1'b0, 5'd3, 5'd2, 12, 5'd7, 1'b1, -1, 1'b1);
    do_txn(5'd31, 1'b1, 5'd4, 5'd3, 10, 5'd31, 1'b0, -1, 1'b0);

    // Reset in the middle of the data phase.
    d0 = done_cnt;
    sent_q.delete();
    @(negedge clk32);
    rt_addr = 5'd3; tr = 1'b0; subaddr = 5'd1; word_count = 5'd4; start = 1'b1;
    @(negedge clk32);
    start = 1'b0;
    budget = 0;
    while (sent_q.size() < 2 && budget < 500) begin
      @(negedge clk32);
      budget++;
    end
    chk("rst_in_tx_data", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    exp_status = '0;
    repeat (3) @(negedge clk32);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    do_txn(5'd3, 1'b0, 5'd1, 5'd4, 15, 5'd3, 1'b0, -1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 32; i++) hw(i, 16'($urandom));
      ra   = 5'($urandom);
      rt   = 1'($urandom);
      sa_r = 5'($urandom);
      rw   = 5'($urandom_range(0, 6));
      rs   = ($urandom_range(0, 7) == 0) ? (ra ^ 5'd1) : ra;
      pe   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_txn(ra, rt, sa_r, rw, int'($urandom_range(4, 40)), rs,
             1'($urandom_range(0, 9) == 0), pe, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
